// File: rtl/mat_mult_pkg.sv
// rtl/mat_mult_pkg.sv - shared state encoding and sizing helpers for mat_mult_seq
package mat_mult_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_e;

    // Wide enough that a full N-term dot product of DW-bit operands never overflows.
    function automatic int acc_width(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

    // Packed-stream slice index of element (i,j); element (0,0) sits in the MSBs.
    function automatic int idx(input int i, input int j, input int n);
        return n * n - 1 - (i * n + j);
    endfunction

endpackage

// File: rtl/mat_mac.sv
// rtl/mat_mac.sv - single multiply-accumulate lane; signed operands when MAT_MULT_SIGNED_EN is defined
module mat_mac #(
    parameter int DW    = 16,
    parameter int ACC_W = 34
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic             last_i,
    input  logic [DW-1:0]    a_i,
    input  logic [DW-1:0]    b_i,
    output logic [ACC_W-1:0] sum_o
);

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

`ifdef MAT_MULT_SIGNED_EN
    logic signed [2*DW-1:0] prod;
    assign prod     = $signed({{DW{a_i[DW-1]}}, a_i}) * $signed({{DW{b_i[DW-1]}}, b_i});
    assign prod_ext = ACC_W'(prod);
`else
    logic [2*DW-1:0] prod;
    assign prod     = {{DW{1'b0}}, a_i} * {{DW{1'b0}}, b_i};
    assign prod_ext = ACC_W'(prod);
`endif

    // The completed dot product is taken from sum_o on the last term, so the
    // accumulator restarts from zero for the next element.
    assign sum_o = acc_q + prod_ext;

    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = last_i ? '0 : sum_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/mat_mult_seq.sv
// rtl/mat_mult_seq.sv - sequential N x N matrix multiplier, one MAC per cycle (option: MAT_MULT_SIGNED_EN)
module mat_mult_seq
    import mat_mult_pkg::*;
#(
    parameter int N     = 3,
    parameter int DW    = 16,
    parameter int ACC_W = acc_width(DW, N)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N*N*DW-1:0]      matrix_a_stream,
    input  logic [N*N*DW-1:0]      matrix_b_stream,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N*N*ACC_W-1:0]   matrix_c_stream,
    output logic                   busy
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;

    logic [DW-1:0]    a_q [N][N];
    logic [DW-1:0]    b_q [N][N];
    logic [ACC_W-1:0] c_q [N][N];

    logic             accept;
    logic             mac_en;
    logic             k_last;
    logic [DW-1:0]    a_el, b_el;
    logic [ACC_W-1:0] mac_sum;

    assign accept   = in_valid && (state_q == IDLE);
    assign mac_en   = (state_q == COMPUTE);
    assign k_last   = (k_q == LAST);

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == COMPUTE);

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = COMPUTE;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            COMPUTE: begin
                if (k_last) begin
                    k_d = '0;
                    if (j_q == LAST) begin
                        j_d = '0;
                        if (i_q == LAST) begin
                            i_d     = '0;
                            state_d = DONE;
                        end else begin
                            i_d = i_q + CW'(1);
                        end
                    end else begin
                        j_d = j_q + CW'(1);
                    end
                end else begin
                    k_d = k_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
        end
    end

    // Operand selection: A[i][k] and B[k][j] for the current MAC step.
    always_comb begin
        a_el = '0;
        b_el = '0;
        for (int ii = 0; ii < N; ii++) begin
            for (int kk = 0; kk < N; kk++) begin
                if (CW'(ii) == i_q && CW'(kk) == k_q) begin
                    a_el = a_q[ii][kk];
                end
                if (CW'(ii) == k_q && CW'(kk) == j_q) begin
                    b_el = b_q[ii][kk];
                end
            end
        end
    end

    mat_mac #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst),
        .clear_i (accept),
        .en_i    (mac_en),
        .last_i  (k_last),
        .a_i     (a_el),
        .b_i     (b_el),
        .sum_o   (mac_sum)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int ii = 0; ii < N; ii++) begin
                for (int jj = 0; jj < N; jj++) begin
                    a_q[ii][jj] <= '0;
                    b_q[ii][jj] <= '0;
                    c_q[ii][jj] <= '0;
                end
            end
        end else if (accept) begin
            for (int ii = 0; ii < N; ii++) begin
                for (int jj = 0; jj < N; jj++) begin
                    a_q[ii][jj] <= matrix_a_stream[idx(ii, jj, N)*DW +: DW];
                    b_q[ii][jj] <= matrix_b_stream[idx(ii, jj, N)*DW +: DW];
                    c_q[ii][jj] <= '0;
                end
            end
        end else if (mac_en && k_last) begin
            for (int ii = 0; ii < N; ii++) begin
                for (int jj = 0; jj < N; jj++) begin
                    if (CW'(ii) == i_q && CW'(jj) == j_q) begin
                        c_q[ii][jj] <= mac_sum;
                    end
                end
            end
        end
    end

    always_comb begin
        matrix_c_stream = '0;
        for (int ii = 0; ii < N; ii++) begin
            for (int jj = 0; jj < N; jj++) begin
                matrix_c_stream[idx(ii, jj, N)*ACC_W +: ACC_W] = c_q[ii][jj];
            end
        end
    end

endmodule
